// File: rtl/rate_divider_enable.sv
// Rate divider producing a one-cycle enable pulse every L(sel)+1 clock cycles.
// Optional heartbeat LED toggle register is built only when RATE_TICK_LED_EN is defined.
module rate_divider_enable #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned WIDTH  = 28
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             run,
  input  logic [1:0]       sel,
  output logic             enable_out,
  output logic [WIDTH-1:0] count_q,
  output logic             tick_led
);

  // Reload values, computed at 64 bits before narrowing so nothing wraps early.
  localparam logic [WIDTH-1:0] LOAD_00 = '0;
  localparam logic [WIDTH-1:0] LOAD_01 = WIDTH'(64'(CLK_HZ) - 64'd1);
  localparam logic [WIDTH-1:0] LOAD_10 = WIDTH'(64'(CLK_HZ) * 64'd2 - 64'd1);
  localparam logic [WIDTH-1:0] LOAD_11 = WIDTH'(64'(CLK_HZ) * 64'd4 - 64'd1);

  logic [1:0]       sel_q;
  logic [1:0]       sel_d;
  logic [WIDTH-1:0] count_d;
  logic             enable_q;
  logic             enable_d;

  function automatic logic [WIDTH-1:0] load_of(input logic [1:0] s);
    logic [WIDTH-1:0] l;
    case (s)
      2'b00:   l = LOAD_00;
      2'b01:   l = LOAD_01;
      2'b10:   l = LOAD_10;
      default: l = LOAD_11;
    endcase
    return l;
  endfunction

  // Rate change beats pause, pause beats countdown; a change never pulses.
  always_comb begin
    sel_d    = sel_q;
    count_d  = count_q;
    enable_d = 1'b0;
    if (sel != sel_q) begin
      sel_d   = sel;
      count_d = load_of(sel);
    end else if (run) begin
      if (count_q == '0) begin
        enable_d = 1'b1;
        count_d  = load_of(sel_q);
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sel_q    <= 2'b00;
      count_q  <= '0;
      enable_q <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      count_q  <= count_d;
      enable_q <= enable_d;
    end
  end

  assign enable_out = enable_q;

`ifdef RATE_TICK_LED_EN
  logic tick_q;

  // Toggles on every pulse, giving a half-rate square wave.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      tick_q <= 1'b0;
    end else if (enable_d) begin
      tick_q <= ~tick_q;
    end
  end

  assign tick_led = tick_q;
`else
  assign tick_led = 1'b0;
`endif

endmodule

// File: tb/tb_rate_divider_enable.sv
// Self-checking bench for rate_divider_enable: directed scenarios plus random run/sel/clear
// traffic, all compared against a phase-based reference model.
module tb_rate_divider_enable;

  localparam int unsigned CLK_HZ = 4;
  localparam int unsigned WIDTH  = 8;

  logic             clk;
  logic             clear;
  logic             run;
  logic [1:0]       sel;
  logic             enable_out;
  logic [WIDTH-1:0] count_q;
  logic             tick_led;

  int n_total;
  int n_bad;

  // Model state: active rate, cycles elapsed in the current period, last pulse, LED.
  int unsigned m_sel;
  int unsigned m_phase;
  bit          m_en;
  bit          m_tick;

  rate_divider_enable #(.CLK_HZ(CLK_HZ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .clear     (clear),
    .run       (run),
    .sel       (sel),
    .enable_out(enable_out),
    .count_q   (count_q),
    .tick_led  (tick_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Pulse period is CLK_HZ * 2^(sel-1) cycles, or 1 cycle for sel=0.
  function automatic int unsigned load_of(input int unsigned s);
    if (s == 0) return 0;
    return (CLK_HZ << (s - 1)) - 1;
  endfunction

  function automatic int unsigned m_count();
    return load_of(m_sel) - m_phase;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel   = 0;
    m_phase = 0;
    m_en    = 1'b0;
    m_tick  = 1'b0;
  endtask

  task automatic model_edge();
    int unsigned period;
    if (32'(sel) != m_sel) begin
      m_sel   = 32'(sel);
      m_phase = 0;
      m_en    = 1'b0;
    end else if (!run) begin
      m_en = 1'b0;
    end else begin
      period  = load_of(m_sel) + 1;
      m_phase = (m_phase + 1) % period;
      m_en    = (m_phase == 0);
      if (m_en) m_tick = ~m_tick;
    end
  endtask

  task automatic check_model(input string tag);
    bit tick_exp;
`ifdef RATE_TICK_LED_EN
    tick_exp = m_tick;
`else
    tick_exp = 1'b0;
`endif
    check_eq({tag, ".count"}, 32'(count_q), m_count());
    check_eq({tag, ".en"}, 32'(enable_out), 32'(m_en));
    check_eq({tag, ".tick"}, 32'(tick_led), 32'(tick_exp));
  endtask

  // One clock edge: model follows the inputs seen at the edge, outputs sampled on negedge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model(tag);
  endtask

  // Asynchronous clear raised between edges; caller is at a negedge.
  task automatic mid_clear();
    #2 clear = 1'b1;
    #1;
    model_reset();
    check_model("async_clr");
    @(negedge clk);
    check_model("clr_held");
    clear = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    clear   = 1'b1;
    run     = 1'b0;
    sel     = 2'b00;
    model_reset();

    @(negedge clk);
    check_model("reset");
    check_eq("reset.count_const", 32'(count_q), 0);
    clear = 1'b0;
    run   = 1'b1;

    // Every-cycle mode straight after reset.
    for (int i = 0; i < 5; i++) begin
      cycle("sel00");
      check_eq("sel00.en_const", 32'(enable_out), 1);
      check_eq("sel00.cnt_const", 32'(count_q), 0);
    end

    // 00 -> 01: reload to 3 with no pulse, then pulses every 4 edges.
    sel = 2'b01;
    cycle("to01");
    check_eq("to01.load", 32'(count_q), 3);
    check_eq("to01.nopulse", 32'(enable_out), 0);
    for (int i = 1; i <= 12; i++) begin
      cycle("run01");
      check_eq("run01.pulse", 32'(enable_out), ((i % 4) == 0) ? 1 : 0);
    end

    // 0.5 Hz with a pause at count 5.
    sel = 2'b10;
    cycle("to10");
    cycle("run10");
    cycle("run10");
    check_eq("run10.at5", 32'(count_q), 5);
    run = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle("pause");
      check_eq("pause.hold", 32'(count_q), 5);
      check_eq("pause.en", 32'(enable_out), 0);
    end
    run = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cycle("resume");
      check_eq("resume.pulse", 32'(enable_out), (i == 6) ? 1 : 0);
    end

    // 0.25 Hz, switched to 1 Hz at count 9.
    sel = 2'b11;
    cycle("to11");
    for (int i = 0; i < 6; i++) cycle("run11");
    check_eq("run11.at9", 32'(count_q), 9);
    sel = 2'b01;
    cycle("11to01");
    check_eq("11to01.load", 32'(count_q), 3);
    check_eq("11to01.nopulse", 32'(enable_out), 0);
    for (int i = 1; i <= 4; i++) begin
      cycle("after_chg");
      check_eq("after_chg.pulse", 32'(enable_out), (i == 4) ? 1 : 0);
    end

    // Clear mid-period discards the partial count.
    cycle("pre_clr");
    mid_clear();
    sel = 2'b00;
    cycle("post_clr");
    check_eq("post_clr.first_pulse", 32'(enable_out), 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      run = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 19) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) mid_clear();
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rate_divider_enable.md
Name: rate_divider_enable

Overview:
- Upstream stage of the 8-bit T-flip-flop display counter.
- Divides the 50 MHz board clock into a one-cycle enable pulse. The rate is chosen by a 2-bit select: every cycle, 1 Hz, 0.5 Hz or 0.25 Hz.
- The pulse drives the counter's enable input, so the counter advances at a human-visible rate while sharing the board clock.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency. Load values derive from it.
- WIDTH, 28, down-counter width. Must hold 4*CLK_HZ-1.

Ports:
- clk  input  1  board clock; all state changes on its rising edge.
- clear  input  1  reset; asynchronous, active-high.
- run  input  1  1 = divider counts; 0 = divider paused.
- sel  input  2  rate select: 00 every cycle, 01 1 Hz, 10 0.5 Hz, 11 0.25 Hz.
- enable_out  output  1  registered one-cycle pulse to the downstream counter enable.
- count_q  output  WIDTH  current down-counter value, for debug and verification.
- tick_led  output  1  heartbeat LED. See Optional Feature.

Behaviour:
- Load values:
  - L(00) = 0
  - L(01) = CLK_HZ-1
  - L(10) = 2*CLK_HZ-1
  - L(11) = 4*CLK_HZ-1
  - Compute at WIDTH bits, no truncation.
- Pulse period = L(sel)+1 clock cycles.
- Internal registers: count (WIDTH), sel_q (2), enable_out (1), tick_led (1).
- Reset (clear=1, asynchronous, takes effect immediately, overrides clk):
  - count=0, sel_q=00, enable_out=0, tick_led=0.
- Rising edge with clear=0, evaluated in priority order:
  1. sel != sel_q (regardless of run): sel_q<=sel, count<=L(sel), enable_out<=0.
  2. run=0: count holds, enable_out<=0.
  3. count==0: enable_out<=1, count<=L(sel_q).
  4. Otherwise: count<=count-1, enable_out<=0.
- enable_out is high for exactly one cycle per period. It is never high for two consecutive cycles, except with sel=00, where it stays high every cycle while run=1.
- Latency:
  - After a reload, the first pulse appears L+1 edges later.
  - Entering sel=00: one edge to reload, then pulses start on the next edge.
- Pause: run falling mid-count freezes count. run rising resumes the countdown from the frozen value, so no phase is lost.
- Rate change mid-count restarts the period at the new rate. No pulse is emitted on the change edge, even if count==0.
- Wrap-around: count never decrements below 0; zero always reloads.
- Reset mid-period discards the partial count.
- After reset with sel=00 and run=1, the first edge yields enable_out=1.

Optional Feature:
- Macro: RATE_TICK_LED_EN.
- Defined: tick_led toggles on every edge at which enable_out is set to 1, giving a visible half-rate square wave on an LEDR.
- Undefined: tick_led is tied to 0 and no toggle register is synthesized.
- Port list is identical in both builds.

Test Plan:
- CLK_HZ=4 for all scenarios (loads 0, 3, 7, 15).
- Reset: assert clear between edges -> count_q=0, enable_out=0, tick_led=0 immediately, with no clk edge needed.
- sel=00, run=1 after reset -> enable_out=1 on every edge; count_q stays 0.
- sel changed 00->01, run=1 -> one edge loads count_q=3. Pulses then fall on edges 4, 8 and 12 after the load; count_q follows 2,1,0,3,...
- sel=10, run dropped at count_q=5 for 6 cycles -> count_q holds 5, enable_out=0. After run rises, the pulse comes 6 edges later.
- sel=11, changed to 01 at count_q=9 -> count_q=3 on that edge with no pulse; the next pulse comes 4 edges later.
- RATE_TICK_LED_EN defined, sel=01, 3 pulses -> tick_led sequence 1,0,1. Undefined -> tick_led constant 0.
